vga_pattern_gen: RTL and testbench

Upstream pixel-colour stage for the 800x600 VGA timing block. Takes the timing block's registered pixel coordinates, `video_on` and a per-frame pulse, and produces an 8-bit RRRGGGBB colour through a 2-stage pipeline. Holds a button-selected pattern mode, debounced on-chip and applied only at frame boundaries, plus a per-frame scroll offset for the animated mode.

---
 rtl/vga_pkg.sv | 55 +++++
 rtl/btn_debounce.sv | 88 ++++++++
 rtl/vga_pattern_gen.sv | 111 +++++++++++
 tb/tb_vga_pattern_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, encodings and helpers for the VGA pattern generator.
package vga_pkg;

  localparam int unsigned H_DISP = 800;
  localparam int unsigned V_DISP = 600;

  localparam logic [7:0] COL_WHITE   = 8'hFF;
  localparam logic [7:0] COL_YELLOW  = 8'hFC;
  localparam logic [7:0] COL_CYAN    = 8'h1F;
  localparam logic [7:0] COL_GREEN   = 8'h1C;
  localparam logic [7:0] COL_MAGENTA = 8'hE3;
  localparam logic [7:0] COL_RED     = 8'hE0;
  localparam logic [7:0] COL_BLUE    = 8'h03;
  localparam logic [7:0] COL_BLACK   = 8'h00;

  typedef enum logic [1:0] {
    MODE_VSTRIPE = 2'd0,
    MODE_HSTRIPE = 2'd1,
    MODE_CHECK   = 2'd2,
    MODE_BARS    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_REL_WAIT
  } db_state_e;

  // Comparator chain against k*w; avoids a divider.
  function automatic logic [2:0] stripe_index(input logic [9:0] v, input int unsigned w);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if ({22'd0, v} >= k * w) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = COL_WHITE;
      3'd1:    c = COL_YELLOW;
      3'd2:    c = COL_CYAN;
      3'd3:    c = COL_GREEN;
      3'd4:    c = COL_MAGENTA;
      3'd5:    c = COL_RED;
      3'd6:    c = COL_BLUE;
      default: c = COL_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debounce FSM; emits a one-cycle press pulse
// when a press has been stable for DEBOUNCE_CYC cycles.
module btn_debounce
  import vga_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic press
);

  localparam logic [18:0] CNT_LAST = 19'(DEBOUNCE_CYC - 1);

  logic [1:0]  sync_q, sync_d;
  db_state_e   state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic        press_q, press_d;
  logic        sync;

  assign sync = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], btn_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    case (state_q)
      DB_IDLE: begin
        if (sync) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      DB_PRESS_WAIT: begin
        if (!sync) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 19'd1;
        end
      end
      DB_HELD: begin
        if (!sync) begin
          state_d = DB_REL_WAIT;
          cnt_d   = '0;
        end
      end
      DB_REL_WAIT: begin
        if (sync) begin
          state_d = DB_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 19'd1;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage: button-selected test pattern, frame-synchronous mode
// changes, scrolling colour bars, 2-cycle registered colour pipeline.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP       = vga_pkg::H_DISP,
  parameter int unsigned V_DISP       = vga_pkg::V_DISP,
  parameter int unsigned STRIPE_W     = 100,
  parameter int unsigned SCROLL_STEP  = 4,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       video_on,
  input  logic       frame_start,
  input  logic       btn_mode,
  output logic [7:0] color,
  output logic       color_valid,
  output logic [1:0] mode
);

  localparam logic [10:0] H_DISP_W = 11'(H_DISP);

  logic press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_mode),
    .press  (press)
  );

  logic [1:0]  mode_q, mode_d;
  logic [9:0]  off_q, off_d;
  logic        req_q, req_d;
  logic [10:0] off_sum, xs_sum;
  logic [9:0]  xs;
  logic [1:0]  mode1_q, mode1_d;
  logic [2:0]  ix1_q, ix1_d, iy1_q, iy1_d;
  logic        von1_q, von1_d;
  logic [7:0]  color_q, color_d;
  logic        valid_q, valid_d;

  // A press landing on the frame_start cycle survives the clear.
  always_comb begin
    req_d   = press | (req_q & ~frame_start);
    mode_d  = mode_q;
    off_d   = off_q;
    off_sum = {1'b0, off_q} + 11'(SCROLL_STEP);
    if (frame_start) begin
      if (req_q) begin
        mode_d = mode_q + 2'd1;
        off_d  = '0;
      end else if (mode_q == MODE_BARS) begin
        off_d = (off_sum >= H_DISP_W) ? 10'(off_sum - H_DISP_W) : 10'(off_sum);
      end
    end
  end

  always_comb begin
    xs_sum  = {1'b0, pixel_x} + ((mode_q == MODE_BARS) ? {1'b0, off_q} : 11'd0);
    xs      = (xs_sum >= H_DISP_W) ? 10'(xs_sum - H_DISP_W) : 10'(xs_sum);
    mode1_d = mode_q;
    ix1_d   = stripe_index(xs, STRIPE_W);
    iy1_d   = stripe_index(pixel_y, STRIPE_W);
    von1_d  = video_on & ({22'd0, pixel_x} < H_DISP) & ({22'd0, pixel_y} < V_DISP);
  end

  always_comb begin
    color_d = '0;
    case (mode1_q)
      MODE_VSTRIPE: color_d = ix1_q[0] ? COL_RED : COL_BLACK;
      MODE_HSTRIPE: color_d = iy1_q[0] ? COL_GREEN : COL_BLACK;
      MODE_CHECK:   color_d = (ix1_q[0] ^ iy1_q[0]) ? COL_BLUE : COL_RED;
      default:      color_d = bar_color(ix1_q);
    endcase
    if (!von1_q) color_d = '0;
    valid_d = von1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= '0;
      off_q   <= '0;
      req_q   <= 1'b0;
      mode1_q <= '0;
      ix1_q   <= '0;
      iy1_q   <= '0;
      von1_q  <= 1'b0;
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      off_q   <= off_d;
      req_q   <= req_d;
      mode1_q <= mode1_d;
      ix1_q   <= ix1_d;
      iy1_q   <= iy1_d;
      von1_q  <= von1_d;
      color_q <= color_d;
      valid_q <= valid_d;
    end
  end

  assign color       = color_q;
  assign color_valid = valid_q;
  assign mode        = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: randomized pixels against an
// arithmetic reference of the pattern rules, plus button/frame scenarios.
module tb_vga_pattern_gen;

  localparam int unsigned H      = 800;
  localparam int unsigned STRIPE = 100;
  localparam int unsigned STEP   = 4;
  localparam int unsigned DB     = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       video_on = 1'b0;
  logic       frame_start = 1'b0;
  logic       btn_mode = 1'b0;
  logic [7:0] color;
  logic       color_valid;
  logic [1:0] mode;

  vga_pattern_gen #(
    .H_DISP(800), .V_DISP(600), .STRIPE_W(STRIPE), .SCROLL_STEP(STEP), .DEBOUNCE_CYC(DB)
  ) dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .btn_mode(btn_mode),
    .color(color), .color_valid(color_valid), .mode(mode)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          chk;
    logic        v;
    logic [7:0]  c;
  } pix_t;

  typedef struct {
    int unsigned cyc;
    bit          full;
    logic [1:0]  m;
  } mchk_t;

  pix_t  q[$];
  mchk_t mq[$];
  int vectors = 0;
  int miscompares = 0;

  int m_mode = 0;
  int m_off  = 0;
  bit m_req  = 0;

  logic [7:0] bars [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

  function automatic logic [7:0] ref_color(int md, int off, int x, int y, bit von);
    int xs, ix, iy;
    if (!von) return 8'h00;
    xs = (x + ((md == 3) ? off : 0)) % H;
    ix = xs / STRIPE;
    iy = y / STRIPE;
    case (md)
      0:       return (ix % 2 == 1) ? 8'hE0 : 8'h00;
      1:       return (iy % 2 == 1) ? 8'h1C : 8'h00;
      2:       return ((ix + iy) % 2 == 0) ? 8'hE0 : 8'h03;
      default: return bars[ix];
    endcase
  endfunction

  always @(negedge clk) begin
    mchk_t mx;
    pix_t  px;
    while (mq.size() > 0 && mq[0].cyc <= cyc) begin
      mx = mq.pop_front();
      vectors++;
      if (mode !== mx.m) begin
        miscompares++;
        $display("FAIL mode @%0d: got %0d expected %0d", cyc, mode, mx.m);
      end
      if (mx.full) begin
        vectors += 2;
        if (color !== 8'h00) begin
          miscompares++;
          $display("FAIL reset_color @%0d: got %h expected 00", cyc, color);
        end
        if (color_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_valid @%0d: got %b expected 0", cyc, color_valid);
        end
      end
    end
    if (reset) begin
      while (q.size() > 0 && q[0].cyc + 2 <= cyc) begin
        px = q.pop_front();
        if (px.chk) begin
          vectors++;
          if (color !== px.c || color_valid !== px.v) begin
            miscompares++;
            $display("FAIL pixel @%0d: got color=%h valid=%b expected color=%h valid=%b",
                     cyc, color, color_valid, px.c, px.v);
          end
        end
      end
    end
  end

  task automatic cycle(input int x, input int y, input bit von, input bit fs, input bit chk);
    pix_t  e;
    mchk_t m;
    @(posedge clk);
    #1;
    if (chk) begin
      m.cyc = cyc; m.full = 1'b0; m.m = 2'(m_mode);
      mq.push_back(m);
    end
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    video_on = von;
    frame_start = fs;
    e.cyc = cyc; e.chk = chk; e.v = von;
    e.c = ref_color(m_mode, m_off, x, y, von);
    q.push_back(e);
    if (fs && chk) begin
      if (m_req) begin
        m_mode = (m_mode + 1) % 4;
        m_off  = 0;
        m_req  = 0;
      end else if (m_mode == 3) begin
        m_off = (m_off + STEP) % H;
      end
    end
  endtask

  task automatic rnd(input int n);
    bit von;
    for (int i = 0; i < n; i++) begin
      von = ($urandom_range(0, 3) != 0);
      if (von) cycle($urandom_range(0, 799), $urandom_range(0, 599), 1'b1, 1'b0, 1'b1);
      else     cycle(0, 0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic frame_pulse();
    cycle(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic clean_press();
    btn_mode = 1'b1;
    rnd(DB + 10);
    btn_mode = 1'b0;
    rnd(DB + 10);
    m_req = 1;
  endtask

  task automatic push_full_check();
    mchk_t m;
    m.cyc = cyc; m.full = 1'b1; m.m = 2'd0;
    mq.push_back(m);
  endtask

  initial begin
    // reset state at time zero
    #2;
    push_full_check();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // mode 0: stripe boundaries then random pixels
    cycle(99, 0, 1'b1, 1'b0, 1'b1);
    cycle(100, 0, 1'b1, 1'b0, 1'b1);
    cycle(799, 0, 1'b1, 1'b0, 1'b1);
    cycle(0, 0, 1'b1, 1'b0, 1'b1);
    rnd(200);
    frame_pulse();
    rnd(20);

    // bouncing button followed by a long hold: one advance
    for (int i = 0; i < 20; i++) begin
      btn_mode = ~btn_mode;
      rnd(10);
    end
    btn_mode = 1'b1;
    rnd(3 * DB);
    btn_mode = 1'b0;
    rnd(DB + 10);
    m_req = 1;
    rnd(20);
    frame_pulse();
    cycle(0, 150, 1'b1, 1'b0, 1'b1);
    cycle(0, 99, 1'b1, 1'b0, 1'b1);
    rnd(100);
    frame_pulse();
    rnd(20);

    // two presses in one frame: single advance
    clean_press();
    clean_press();
    frame_pulse();
    rnd(50);
    cycle(150, 50, 1'b1, 1'b0, 1'b1);
    cycle(150, 150, 1'b1, 1'b0, 1'b1);
    cycle(150, 150, 1'b0, 1'b0, 1'b1);
    rnd(50);

    // asynchronous reset mid-frame in mode 2
    cycle(150, 50, 1'b1, 1'b0, 1'b1);
    cycle(150, 50, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    push_full_check();
    q.delete();
    btn_mode = 1'b0;
    m_mode = 0; m_off = 0; m_req = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rnd(20);

    // press completing while frame_start is asserted every cycle
    btn_mode = 1'b1;
    for (int i = 0; i < int'(DB) + 20; i++) cycle(0, 0, 1'b0, 1'b1, 1'b0);
    m_mode = 1; m_off = 0; m_req = 0;
    btn_mode = 1'b0;
    rnd(DB + 10);

    // reach mode 3
    clean_press();
    frame_pulse();
    rnd(10);
    clean_press();
    frame_pulse();

    // scrolling bars through a full wrap of the offset
    for (int i = 0; i < 200; i++) begin
      rnd(3);
      if (m_off == 796) begin
        cycle(3, 10, 1'b1, 1'b0, 1'b1);
        cycle(4, 10, 1'b1, 1'b0, 1'b1);
      end
      frame_pulse();
    end
    frame_pulse();
    cycle(96, 300, 1'b1, 1'b0, 1'b1);
    cycle(95, 300, 1'b1, 1'b0, 1'b1);
    cycle(799, 300, 1'b1, 1'b0, 1'b1);
    rnd(100);

    // wrap mode 3 -> 0
    clean_press();
    frame_pulse();
    cycle(50, 0, 1'b1, 1'b0, 1'b1);
    cycle(150, 0, 1'b1, 1'b0, 1'b1);
    rnd(50);

    repeat (4) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
